// File: rtl/unified_cache_write_back_buffer_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : unified_cache_write_back_buffer_pkg                           |
// | Brief  : Shared sizing for the unified cache write-back buffer and its |
// |          neighbours (line-address slice used by main_ctrl too).        |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
package unified_cache_write_back_buffer_pkg;

   localparam int UNIFIED_CACHE_BLOCK_SIZE_IN_BITS = 512;

   // Line address is the byte address with the 64-byte line offset removed.
   localparam int UNIFIED_CACHE_LINE_ADDR_POS_HI = 31;
   localparam int UNIFIED_CACHE_LINE_ADDR_POS_LO = 6;

   localparam int UNIFIED_CACHE_WBB_NUMBER_ENTRIES = 4;
   localparam int UNIFIED_CACHE_WBB_PTR_WIDTH      = $clog2(UNIFIED_CACHE_WBB_NUMBER_ENTRIES);

endpackage
`default_nettype wire

// File: rtl/unified_cache_wbb_cam.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : unified_cache_wbb_cam                                         |
// | Brief  : Combinational address CAM over the write-back buffer entries. |
// | Ports  : probe_addr_in   - address searched for                        |
// |          entry_addrs_in  - packed entry addresses, entry i at i*AW     |
// |          entry_valid_in  - per-entry qualifier (caller may mask)       |
// |          match_out       - per-entry match vector                      |
// |          hit_out         - any entry matched                           |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
module unified_cache_wbb_cam #(
   parameter int NUMBER_ENTRIES          = 4,
   parameter int LINE_ADDR_WIDTH_IN_BITS = 26
) (
   input  logic [LINE_ADDR_WIDTH_IN_BITS-1:0]                probe_addr_in,
   input  logic [NUMBER_ENTRIES*LINE_ADDR_WIDTH_IN_BITS-1:0] entry_addrs_in,
   input  logic [NUMBER_ENTRIES-1:0]                         entry_valid_in,
   output logic [NUMBER_ENTRIES-1:0]                         match_out,
   output logic                                              hit_out
);

   genvar g;
   generate
      for (g = 0; g < NUMBER_ENTRIES; g++) begin : g_match
         assign match_out[g] = entry_valid_in[g] &&
            (entry_addrs_in[g*LINE_ADDR_WIDTH_IN_BITS +: LINE_ADDR_WIDTH_IN_BITS] == probe_addr_in);
      end
   endgenerate

   assign hit_out = |match_out;

endmodule
`default_nettype wire

// File: rtl/unified_cache_write_back_buffer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : unified_cache_write_back_buffer                               |
// | Brief  : Circular FIFO of dirty evicted lines with address coalescing  |
// |          and a registered probe (CAM) lookup for main stage 1.         |
// | Ports  : clk_in / reset_in (async, active-low)                         |
// |          evict_*      - eviction push from main_ctrl (valid/ready)     |
// |          lookup_*     - probe in, registered hit/data out              |
// |          mem_req_*    - head entry offered to lower memory             |
// |          empty_out, count_out - registered occupancy views             |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
module unified_cache_write_back_buffer
   import unified_cache_write_back_buffer_pkg::*;
#(
   parameter int CACHE_BLOCK_SIZE_IN_BITS = UNIFIED_CACHE_BLOCK_SIZE_IN_BITS,
   parameter int LINE_ADDR_WIDTH_IN_BITS  = UNIFIED_CACHE_LINE_ADDR_POS_HI - UNIFIED_CACHE_LINE_ADDR_POS_LO + 1,
   parameter int NUMBER_ENTRIES           = UNIFIED_CACHE_WBB_NUMBER_ENTRIES,
   parameter int ENTRY_PTR_WIDTH_IN_BITS  = UNIFIED_CACHE_WBB_PTR_WIDTH
) (
   input  logic                                clk_in,
   input  logic                                reset_in,
   input  logic                                evict_valid_in,
   input  logic [LINE_ADDR_WIDTH_IN_BITS-1:0]  evict_line_addr_in,
   input  logic [CACHE_BLOCK_SIZE_IN_BITS-1:0] evict_data_in,
   output logic                                evict_ready_out,
   input  logic                                lookup_en_in,
   input  logic [LINE_ADDR_WIDTH_IN_BITS-1:0]  lookup_line_addr_in,
   output logic                                lookup_hit_out,
   output logic [CACHE_BLOCK_SIZE_IN_BITS-1:0] lookup_data_out,
   output logic                                mem_req_valid_out,
   output logic [LINE_ADDR_WIDTH_IN_BITS-1:0]  mem_req_line_addr_out,
   output logic [CACHE_BLOCK_SIZE_IN_BITS-1:0] mem_req_data_out,
   input  logic                                mem_req_ready_in,
   output logic                                empty_out,
   output logic [ENTRY_PTR_WIDTH_IN_BITS:0]    count_out
);

   localparam int AW = LINE_ADDR_WIDTH_IN_BITS;
   localparam int DW = CACHE_BLOCK_SIZE_IN_BITS;
   localparam int N  = NUMBER_ENTRIES;
   localparam int PW = ENTRY_PTR_WIDTH_IN_BITS;
   localparam logic [PW:0] FULL_COUNT = (PW+1)'(N);

   logic [N-1:0]    valid_q, valid_d;
   logic [N*AW-1:0] addr_q, addr_d;
   logic [DW-1:0]   data_q [N];
   logic [DW-1:0]   data_d [N];
   logic [PW-1:0]   head_q, head_d;
   logic [PW-1:0]   tail_q, tail_d;
   logic [PW:0]     count_q, count_d;
   logic            lookup_hit_q, lookup_hit_d;
   logic [DW-1:0]   lookup_data_q, lookup_data_d;

   logic [N-1:0]    head_onehot;
   logic [N-1:0]    lookup_match;
   logic [N-1:0]    coal_match;
   logic            lookup_cam_hit;
   logic            coal_hit;
   logic            push;
   logic            push_new;
   logic            pop;

   assign evict_ready_out       = (count_q != FULL_COUNT);
   assign empty_out             = (count_q == '0);
   assign count_out             = count_q;
   assign mem_req_valid_out     = !empty_out;
   assign mem_req_line_addr_out = addr_q[head_q*AW +: AW];
   assign mem_req_data_out      = data_q[head_q];
   assign lookup_hit_out        = lookup_hit_q;
   assign lookup_data_out       = lookup_data_q;

   assign head_onehot = {{(N-1){1'b0}}, 1'b1} << head_q;

   unified_cache_wbb_cam #(
      .NUMBER_ENTRIES          (N),
      .LINE_ADDR_WIDTH_IN_BITS (AW)
   ) u_lookup_cam (
      .probe_addr_in  (lookup_line_addr_in),
      .entry_addrs_in (addr_q),
      .entry_valid_in (valid_q),
      .match_out      (lookup_match),
      .hit_out        (lookup_cam_hit)
   );

   // The head is excluded so the line being offered to memory never changes
   // under an outstanding request.
   unified_cache_wbb_cam #(
      .NUMBER_ENTRIES          (N),
      .LINE_ADDR_WIDTH_IN_BITS (AW)
   ) u_coalesce_cam (
      .probe_addr_in  (evict_line_addr_in),
      .entry_addrs_in (addr_q),
      .entry_valid_in (valid_q & ~head_onehot),
      .match_out      (coal_match),
      .hit_out        (coal_hit)
   );

   always_comb begin
      push     = evict_valid_in && evict_ready_out;
      pop      = mem_req_valid_out && mem_req_ready_in;
      push_new = push && !coal_hit;

      valid_d = valid_q;
      addr_d  = addr_q;
      data_d  = data_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;

      if (pop) begin
         valid_d[head_q] = 1'b0;
         head_d          = head_q + 1'b1;
      end

      if (push_new) begin
         valid_d[tail_q]           = 1'b1;
         addr_d[tail_q*AW +: AW]   = evict_line_addr_in;
         data_d[tail_q]            = evict_data_in;
         tail_d                    = tail_q + 1'b1;
      end else if (push) begin
         for (int i = 0; i < N; i++) begin
            if (coal_match[i]) begin
               data_d[i] = evict_data_in;
            end
         end
      end

      unique case ({push_new, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      // A same-cycle accepted push of the probed address carries the
      // freshest data, so it takes priority over the stored copy.
      lookup_hit_d  = 1'b0;
      lookup_data_d = '0;
      if (lookup_en_in) begin
         if (push && (evict_line_addr_in == lookup_line_addr_in)) begin
            lookup_hit_d  = 1'b1;
            lookup_data_d = evict_data_in;
         end else if (lookup_cam_hit) begin
            lookup_hit_d = 1'b1;
            for (int i = 0; i < N; i++) begin
               if (lookup_match[i]) begin
                  lookup_data_d = lookup_data_d | data_q[i];
               end
            end
         end
      end
   end

   always_ff @(posedge clk_in or negedge reset_in) begin
      if (!reset_in) begin
         valid_q       <= '0;
         addr_q        <= '0;
         head_q        <= '0;
         tail_q        <= '0;
         count_q       <= '0;
         lookup_hit_q  <= 1'b0;
         lookup_data_q <= '0;
      end else begin
         valid_q       <= valid_d;
         addr_q        <= addr_d;
         head_q        <= head_d;
         tail_q        <= tail_d;
         count_q       <= count_d;
         lookup_hit_q  <= lookup_hit_d;
         lookup_data_q <= lookup_data_d;
      end
   end

   // Line data is qualified by valid_q, so it carries no reset.
   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         data_q <= data_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_unified_cache_write_back_buffer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : tb_unified_cache_write_back_buffer                            |
// | Brief  : Directed bench with a queue-based reference model of the      |
// |          write-back buffer, checked every cycle, plus literal checks.  |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
module tb_unified_cache_write_back_buffer;

   localparam int DW = 512;
   localparam int AW = 26;
   localparam int N  = 4;

   logic            clk_in = 1'b0;
   logic            reset_in;
   logic            evict_valid_in;
   logic [AW-1:0]   evict_line_addr_in;
   logic [DW-1:0]   evict_data_in;
   logic            evict_ready_out;
   logic            lookup_en_in;
   logic [AW-1:0]   lookup_line_addr_in;
   logic            lookup_hit_out;
   logic [DW-1:0]   lookup_data_out;
   logic            mem_req_valid_out;
   logic [AW-1:0]   mem_req_line_addr_out;
   logic [DW-1:0]   mem_req_data_out;
   logic            mem_req_ready_in;
   logic            empty_out;
   logic [2:0]      count_out;

   int checks = 0;
   int errors = 0;

   always #5 clk_in = ~clk_in;

   unified_cache_write_back_buffer #(
      .CACHE_BLOCK_SIZE_IN_BITS (DW),
      .LINE_ADDR_WIDTH_IN_BITS  (AW),
      .NUMBER_ENTRIES           (N),
      .ENTRY_PTR_WIDTH_IN_BITS  (2)
   ) dut (
      .clk_in                (clk_in),
      .reset_in              (reset_in),
      .evict_valid_in        (evict_valid_in),
      .evict_line_addr_in    (evict_line_addr_in),
      .evict_data_in         (evict_data_in),
      .evict_ready_out       (evict_ready_out),
      .lookup_en_in          (lookup_en_in),
      .lookup_line_addr_in   (lookup_line_addr_in),
      .lookup_hit_out        (lookup_hit_out),
      .lookup_data_out       (lookup_data_out),
      .mem_req_valid_out     (mem_req_valid_out),
      .mem_req_line_addr_out (mem_req_line_addr_out),
      .mem_req_data_out      (mem_req_data_out),
      .mem_req_ready_in      (mem_req_ready_in),
      .empty_out             (empty_out),
      .count_out             (count_out)
   );

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the buffer is an ordered list of {addr, data};
   // front is the line offered to memory.
   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } ent_t;

   ent_t          mq[$];
   logic          m_hit;
   logic [DW-1:0] m_data;
   logic          m_push, m_pop, m_coal;

   initial begin
      m_hit  = 1'b0;
      m_data = '0;
      forever begin
         @(posedge clk_in or negedge reset_in);
         if (!reset_in) begin
            mq.delete();
            m_hit  = 1'b0;
            m_data = '0;
         end else begin
            m_push = evict_valid_in && (mq.size() != N);
            m_pop  = (mq.size() != 0) && mem_req_ready_in;
            m_hit  = 1'b0;
            m_data = '0;
            if (lookup_en_in) begin
               if (m_push && evict_line_addr_in == lookup_line_addr_in) begin
                  m_hit  = 1'b1;
                  m_data = evict_data_in;
               end else begin
                  for (int i = 0; i < mq.size(); i++) begin
                     if (mq[i].a == lookup_line_addr_in) begin
                        m_hit  = 1'b1;
                        m_data = mq[i].d;
                     end
                  end
               end
            end
            m_coal = 1'b0;
            if (m_push) begin
               for (int i = 1; i < mq.size(); i++) begin
                  if (mq[i].a == evict_line_addr_in) begin
                     mq[i].d = evict_data_in;
                     m_coal  = 1'b1;
                  end
               end
            end
            if (m_pop) void'(mq.pop_front());
            if (m_push && !m_coal) mq.push_back('{a: evict_line_addr_in, d: evict_data_in});
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   initial begin
      forever begin
         @(negedge clk_in);
         chk("mem_valid", mem_req_valid_out, mq.size() != 0);
         if (mq.size() != 0) begin
            chk("mem_addr", mem_req_line_addr_out, mq[0].a);
            chk("mem_data", mem_req_data_out, mq[0].d);
         end
         chk("count", count_out, mq.size());
         chk("empty", empty_out, mq.size() == 0);
         chk("evict_ready", evict_ready_out, mq.size() != N);
         chk("lookup_hit", lookup_hit_out, m_hit);
         chk("lookup_data", lookup_data_out, m_data);
      end
   end

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic idle();
      evict_valid_in   = 1'b0;
      lookup_en_in     = 1'b0;
      mem_req_ready_in = 1'b0;
   endtask

   task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
      evict_valid_in     = 1'b1;
      evict_line_addr_in = a;
      evict_data_in      = d;
   endtask

   task automatic lookup(input logic [AW-1:0] a);
      lookup_en_in        = 1'b1;
      lookup_line_addr_in = a;
   endtask

   initial begin
      logic [AW-1:0] drain_order [4];
      drain_order = '{26'h2, 26'h3, 26'h4, 26'h5};

      reset_in            = 1'b0;
      evict_line_addr_in  = '0;
      evict_data_in       = '0;
      lookup_line_addr_in = '0;
      idle();
      tick();
      tick();
      chk("rst_empty", empty_out, 1'b1);
      chk("rst_count", count_out, 3'd0);
      chk("rst_ready", evict_ready_out, 1'b1);
      chk("rst_memvalid", mem_req_valid_out, 1'b0);
      chk("rst_hit", lookup_hit_out, 1'b0);
      reset_in = 1'b1;
      tick();

      // Single push then pop.
      push(26'h100, 512'hA);
      tick();
      idle();
      chk("t1_valid", mem_req_valid_out, 1'b1);
      chk("t1_addr", mem_req_line_addr_out, 26'h100);
      chk("t1_data", mem_req_data_out, 512'hA);
      chk("t1_count", count_out, 3'd1);
      mem_req_ready_in = 1'b1;
      tick();
      idle();
      chk("t1_empty", empty_out, 1'b1);

      // Fill, refuse when full even with a pop, then wrap and drain in order.
      for (int i = 1; i <= 4; i++) begin
         push(AW'(i), DW'(i * 16'h1111));
         tick();
      end
      idle();
      chk("t2_full_ready", evict_ready_out, 1'b0);
      chk("t2_full_count", count_out, 3'd4);
      push(26'h5, 512'h5555);
      mem_req_ready_in = 1'b1;
      tick();
      chk("t2_refused_count", count_out, 3'd3);
      mem_req_ready_in = 1'b0;
      tick();
      idle();
      chk("t2_accept_count", count_out, 3'd4);
      mem_req_ready_in = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("t2_drain_addr", mem_req_line_addr_out, drain_order[i]);
         tick();
      end
      idle();
      chk("t2_drained", empty_out, 1'b1);

      // Coalescing into a non-head entry; head address makes a new entry.
      push(26'h10, 512'hA);
      tick();
      push(26'h20, 512'hB);
      tick();
      push(26'h20, 512'hC);
      tick();
      idle();
      lookup(26'h20);
      tick();
      idle();
      chk("t3_coal_count", count_out, 3'd2);
      chk("t3_coal_hit", lookup_hit_out, 1'b1);
      chk("t3_coal_data", lookup_data_out, 512'hC);
      push(26'h10, 512'hD);
      tick();
      idle();
      chk("t3_head_count", count_out, 3'd3);
      mem_req_ready_in = 1'b1;
      chk("t3_d0", mem_req_data_out, 512'hA);
      tick();
      chk("t3_d1", mem_req_data_out, 512'hC);
      tick();
      chk("t3_d2", mem_req_data_out, 512'hD);
      tick();
      idle();
      chk("t3_empty", empty_out, 1'b1);

      // Same-cycle forwarding from an accepted push; miss returns zero.
      push(26'h30, 512'hE);
      lookup(26'h30);
      tick();
      evict_valid_in = 1'b0;
      chk("t4_fwd_hit", lookup_hit_out, 1'b1);
      chk("t4_fwd_data", lookup_data_out, 512'hE);
      lookup(26'h31);
      tick();
      chk("t4_miss_hit", lookup_hit_out, 1'b0);
      chk("t4_miss_data", lookup_data_out, 512'h0);
      idle();
      mem_req_ready_in = 1'b1;
      tick();
      idle();

      // Head popped and probed in the same cycle.
      push(26'h40, 512'h4444);
      tick();
      idle();
      lookup(26'h40);
      mem_req_ready_in = 1'b1;
      tick();
      chk("t5_pop_hit", lookup_hit_out, 1'b1);
      chk("t5_pop_data", lookup_data_out, 512'h4444);
      chk("t5_pop_empty", empty_out, 1'b1);
      mem_req_ready_in = 1'b0;
      tick();
      chk("t5_after_hit", lookup_hit_out, 1'b0);
      idle();

      // Asynchronous reset in the middle of a handshake.
      push(26'h50, 512'h50);
      tick();
      push(26'h51, 512'h51);
      tick();
      push(26'h52, 512'h52);
      lookup(26'h50);
      tick();
      idle();
      chk("t6_count", count_out, 3'd3);
      chk("t6_valid", mem_req_valid_out, 1'b1);
      chk("t6_hit", lookup_hit_out, 1'b1);
      mem_req_ready_in = 1'b1;
      #2;
      reset_in = 1'b0;
      #1;
      chk("t6_rst_valid", mem_req_valid_out, 1'b0);
      chk("t6_rst_count", count_out, 3'd0);
      chk("t6_rst_empty", empty_out, 1'b1);
      chk("t6_rst_ready", evict_ready_out, 1'b1);
      chk("t6_rst_hit", lookup_hit_out, 1'b0);
      chk("t6_rst_data", lookup_data_out, 512'h0);
      idle();
      push(26'h60, 512'h60);
      lookup(26'h60);
      tick();
      chk("t6_ignored_count", count_out, 3'd0);
      chk("t6_ignored_hit", lookup_hit_out, 1'b0);
      idle();
      reset_in = 1'b1;
      tick();
      chk("t6_rel_count", count_out, 3'd0);
      chk("t6_rel_ready", evict_ready_out, 1'b1);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete, got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
